node_rx_endpoint: RTL and testbench

NODE_RX_ENDPOINT -- requirements
Module: node_rx_endpoint

---
 rtl/net_pkg.sv | 18 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/node_rx_endpoint.sv | 85 ++++++++
 tb/tb_node_rx_endpoint.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
// Shared ring-network definitions: packet field positions, widths and a
// saturating-counter helper used by the receive endpoint.
package net_pkg;

  localparam int unsigned ADDR_WIDTH  = 3;
  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned DEST_MSB    = 31;
  localparam int unsigned DEST_LSB    = 29;
  localparam int unsigned MARKER_BIT  = 28;
  localparam int unsigned CNT_WIDTH   = 8;
  localparam int unsigned LEVEL_WIDTH = 5;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
// Ports:
//   clk_i, reset_i       clock and synchronous reset
//   push_i, wdata_i      write request and data (ignored when full unless popping)
//   pop_i                read request (ignored when empty)
//   rdata_o              head word, valid while !empty_o
//   full_o, empty_o      status
//   level_o              number of stored words, 0..Depth
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullLevel = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == FullLevel);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop on the same edge frees the slot, so a full FIFO can still take a word.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Depth is a power of two, so pointer overflow is the modulo wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) level_d = level_q + (PtrW + 1)'(1);
    if (do_pop && !do_push) level_d = level_q - (PtrW + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; it is only observable through level_q.
  always_ff @(posedge clk_i) begin
    if (do_push && !reset_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/node_rx_endpoint.sv
// Receive endpoint for a ring node: filters words from the node's local
// output by destination address and message marker, buffers accepted words
// for the host, and counts words dropped for bad headers or a full buffer.
// Ports:
//   shiftInCLK     clock
//   reset          synchronous active-high reset
//   shiftInCS      word strobe, one word per cycle held high
//   shiftInData    incoming 32-bit packet
//   rxValid/rxData head of receive buffer
//   rxReady        host accepts head word
//   fifoLevel      buffered word count
//   overflowCount  saturating count of words dropped on full buffer
//   misrouteCount  saturating count of words dropped on bad header
module node_rx_endpoint
  import net_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] NODE_IP    = 3'b000,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                   shiftInCLK,
  input  logic                   reset,
  input  logic                   shiftInCS,
  input  logic [WORD_WIDTH-1:0]  shiftInData,
  output logic                   rxValid,
  output logic [WORD_WIDTH-1:0]  rxData,
  input  logic                   rxReady,
  output logic [LEVEL_WIDTH-1:0] fifoLevel,
  output logic [CNT_WIDTH-1:0]   overflowCount,
  output logic [CNT_WIDTH-1:0]   misrouteCount
);

  logic                        header_ok;
  logic                        fifo_full, fifo_empty;
  logic                        pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [CNT_WIDTH-1:0]        ovf_cnt_q, ovf_cnt_d;
  logic [CNT_WIDTH-1:0]        mis_cnt_q, mis_cnt_d;

  assign header_ok = (shiftInData[DEST_MSB:DEST_LSB] == NODE_IP) && shiftInData[MARKER_BIT];
  assign pop       = rxReady && !fifo_empty;

  sync_fifo #(
    .Width (WORD_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (shiftInCLK),
    .reset_i (reset),
    .push_i  (shiftInCS && header_ok),
    .wdata_i (shiftInData),
    .pop_i   (rxReady),
    .rdata_o (rxData),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign rxValid   = !fifo_empty;
  assign fifoLevel = LEVEL_WIDTH'(fifo_level);

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (shiftInCS) begin
      if (!header_ok) begin
        mis_cnt_d = sat_inc(mis_cnt_q);
      end else if (fifo_full && !pop) begin
        ovf_cnt_d = sat_inc(ovf_cnt_q);
      end
    end
  end

  always_ff @(posedge shiftInCLK) begin
    if (reset) begin
      ovf_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign overflowCount = ovf_cnt_q;
  assign misrouteCount = mis_cnt_q;

endmodule

// File: tb/tb_node_rx_endpoint.sv
// Bench for node_rx_endpoint: two instances (ring addresses 0 and 1) share the
// same stimulus; a queue-style model per instance predicts every output.
module tb_node_rx_endpoint;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic [31:0] din = '0;
  logic        rdy = 1'b0;

  logic        v [2];
  logic [31:0] d [2];
  logic [4:0]  l [2];
  logic [7:0]  o [2];
  logic [7:0]  m [2];

  int nchk = 0;
  int nerr = 0;

  // Reference model: circular buffer with head/count per instance.
  logic [31:0] mbuf [2][DEPTH];
  int mhead [2];
  int mcnt  [2];
  int movf  [2];
  int mmis  [2];

  always #5 clk = ~clk;

  node_rx_endpoint #(.NODE_IP(3'd0), .FIFO_DEPTH(DEPTH)) dut0 (
    .shiftInCLK    (clk),
    .reset         (rst),
    .shiftInCS     (cs),
    .shiftInData   (din),
    .rxValid       (v[0]),
    .rxData        (d[0]),
    .rxReady       (rdy),
    .fifoLevel     (l[0]),
    .overflowCount (o[0]),
    .misrouteCount (m[0])
  );

  node_rx_endpoint #(.NODE_IP(3'd1), .FIFO_DEPTH(DEPTH)) dut1 (
    .shiftInCLK    (clk),
    .reset         (rst),
    .shiftInCS     (cs),
    .shiftInData   (din),
    .rxValid       (v[1]),
    .rxData        (d[1]),
    .rxReady       (rdy),
    .fifoLevel     (l[1]),
    .overflowCount (o[1]),
    .misrouteCount (m[1])
  );

  function automatic int sat(input int x);
    return (x >= 255) ? 255 : x + 1;
  endfunction

  // Drive one cycle of inputs from a negedge, advance the model at the
  // posedge, and return at the following negedge ready for sampling.
  task automatic cycle(input logic c, input logic [31:0] w, input logic r, input logic rs);
    logic popped;
    logic hdr;
    cs = c; din = w; rdy = r; rst = rs;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        mhead[k] = 0; mcnt[k] = 0; movf[k] = 0; mmis[k] = 0;
      end else begin
        popped = r && (mcnt[k] > 0);
        hdr = (int'(w[31:29]) == k) && w[28];
        if (popped) begin
          mhead[k] = (mhead[k] + 1) % DEPTH;
          mcnt[k]  = mcnt[k] - 1;
        end
        if (c) begin
          if (!hdr) mmis[k] = sat(mmis[k]);
          else if (mcnt[k] == DEPTH) movf[k] = sat(movf[k]);
          else begin
            mbuf[k][(mhead[k] + mcnt[k]) % DEPTH] = w;
            mcnt[k] = mcnt[k] + 1;
          end
        end
      end
    end
    @(negedge clk);
    cs = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      nchk++;
      if (v[k] !== 1'b0) begin nerr++; $display("FAIL reset_valid[%0d]: got %b want 0", k, v[k]); end
      nchk++;
      if (l[k] !== 5'd0) begin nerr++; $display("FAIL reset_level[%0d]: got %0d want 0", k, l[k]); end
      nchk++;
      if (o[k] !== 8'd0 || m[k] !== 8'd0) begin
        nerr++; $display("FAIL reset_counters[%0d]: got ovf=%0d mis=%0d want 0/0", k, o[k], m[k]);
      end
    end
  endtask

  task automatic test_pass_through();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h10924924, 1'b1, 1'b0);
    nchk++;
    if (v[0] !== 1'b1 || d[0] !== 32'h10924924) begin
      nerr++; $display("FAIL pass_head: got v=%b d=%h want v=1 d=10924924", v[0], d[0]);
    end
    nchk++;
    if (m[0] !== 8'd0 || o[0] !== 8'd0) begin
      nerr++; $display("FAIL pass_counters: got ovf=%0d mis=%0d want 0/0", o[0], m[0]);
    end
    nchk++;
    if (v[1] !== 1'b0 || m[1] !== 8'd1) begin
      nerr++; $display("FAIL misroute_dest: got v=%b mis=%0d want v=0 mis=1", v[1], m[1]);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    nchk++;
    if (v[0] !== 1'b0 || l[0] !== 5'd0) begin
      nerr++; $display("FAIL pass_drained: got v=%b lvl=%0d want v=0 lvl=0", v[0], l[0]);
    end
    cycle(1'b1, 32'h20924924, 1'b1, 1'b0);
    nchk++;
    if (v[1] !== 1'b0 || m[1] !== 8'd2) begin
      nerr++; $display("FAIL misroute_marker: got v=%b mis=%0d want v=0 mis=2", v[1], m[1]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      w = 32'h1000000A + 32'(i);
      cycle(1'b1, w, 1'b0, 1'b0);
    end
    nchk++;
    if (l[0] !== 5'd4) begin nerr++; $display("FAIL ovf_level: got %0d want 4", l[0]); end
    nchk++;
    if (o[0] !== 8'd2) begin nerr++; $display("FAIL ovf_count: got %0d want 2", o[0]); end
    for (int i = 0; i < 4; i++) begin
      w = 32'h1000000A + 32'(i);
      nchk++;
      if (v[0] !== 1'b1 || d[0] !== w) begin
        nerr++; $display("FAIL ovf_drain%0d: got v=%b d=%h want v=1 d=%h", i, v[0], d[0], w);
      end
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    nchk++;
    if (v[0] !== 1'b0) begin nerr++; $display("FAIL ovf_empty: got v=%b want 0", v[0]); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] w;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10000100 + 32'(i), 1'b0, 1'b0);
    nchk++;
    if (l[0] !== 5'd4 || d[0] !== 32'h10000100) begin
      nerr++; $display("FAIL full_pre: got lvl=%0d d=%h want lvl=4 d=10000100", l[0], d[0]);
    end
    cycle(1'b1, 32'h10000104, 1'b1, 1'b0);
    nchk++;
    if (l[0] !== 5'd4 || o[0] !== 8'd0) begin
      nerr++; $display("FAIL full_pushpop: got lvl=%0d ovf=%0d want lvl=4 ovf=0", l[0], o[0]);
    end
    for (int i = 1; i < 5; i++) begin
      w = 32'h10000100 + 32'(i);
      nchk++;
      if (v[0] !== 1'b1 || d[0] !== w) begin
        nerr++; $display("FAIL full_drain%0d: got v=%b d=%h want v=1 d=%h", i, v[0], d[0], w);
      end
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    nchk++;
    if (l[0] !== 5'd0) begin nerr++; $display("FAIL full_end_level: got %0d want 0", l[0]); end
  endtask

  task automatic test_reset_midstream();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h10000200 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h00000000, 1'b0, 1'b0);
    nchk++;
    if (l[0] !== 5'd3 || m[0] !== 8'd1) begin
      nerr++; $display("FAIL mid_pre: got lvl=%0d mis=%0d want lvl=3 mis=1", l[0], m[0]);
    end
    cycle(1'b1, 32'h10000255, 1'b0, 1'b1);
    nchk++;
    if (l[0] !== 5'd0 || v[0] !== 1'b0) begin
      nerr++; $display("FAIL mid_buffer: got lvl=%0d v=%b want lvl=0 v=0", l[0], v[0]);
    end
    nchk++;
    if (o[0] !== 8'd0 || m[0] !== 8'd0 || m[1] !== 8'd0) begin
      nerr++; $display("FAIL mid_counters: got ovf=%0d mis=%0d/%0d want 0", o[0], m[0], m[1]);
    end
  endtask

  task automatic test_saturation();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) cycle(1'b1, 32'h00000000, 1'b1, 1'b0);
    nchk++;
    if (m[1] !== 8'hFF || m[0] !== 8'hFF) begin
      nerr++; $display("FAIL sat_reach: got %h/%h want ff/ff", m[0], m[1]);
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'h20000000, 1'b1, 1'b0);
    nchk++;
    if (m[1] !== 8'hFF) begin nerr++; $display("FAIL sat_hold: got %h want ff", m[1]); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic        c, r, rs;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      w = $urandom;
      w[31:29] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      w[28] = ($urandom_range(0, 4) != 0);
      c  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 127) == 0);
      cycle(c, w, r, rs);
      for (int k = 0; k < 2; k++) begin
        nchk++;
        if (l[k] !== 5'(mcnt[k]) || v[k] !== (mcnt[k] != 0)) begin
          nerr++; $display("FAIL rnd_level[%0d] @%0d: got lvl=%0d v=%b want lvl=%0d", k, n, l[k], v[k], mcnt[k]);
        end
        if (mcnt[k] != 0) begin
          nchk++;
          if (d[k] !== mbuf[k][mhead[k]]) begin
            nerr++; $display("FAIL rnd_data[%0d] @%0d: got %h want %h", k, n, d[k], mbuf[k][mhead[k]]);
          end
        end
        nchk++;
        if (o[k] !== 8'(movf[k]) || m[k] !== 8'(mmis[k])) begin
          nerr++; $display("FAIL rnd_counters[%0d] @%0d: got ovf=%0d mis=%0d want %0d/%0d",
                           k, n, o[k], m[k], movf[k], mmis[k]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; mcnt[k] = 0; movf[k] = 0; mmis[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_overflow();
    test_full_push_pop();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
